// File: rtl/fix_read_pkg.sv
// rtl/fix_read_pkg.sv - shared types and helpers for the FIX message read controller
package fix_read_pkg;

    // Result bus width; matches the default message-buffer address width.
    localparam int RES_ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOC_RD,
        ST_LOC_WAIT,
        ST_SEARCH_REQ,
        ST_SEARCH_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_IDX     = 3'd1,
        ERR_EMPTY   = 3'd2,
        ERR_RANGE   = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_t;

    typedef struct packed {
        logic                      found;
        logic [RES_ADDR_WIDTH-1:0] value_addr;
        err_t                      err;
    } result_t;

    function automatic logic is_timed(input state_t s);
        return (s == ST_LOC_WAIT) || (s == ST_SEARCH_REQ) || (s == ST_SEARCH_WAIT);
    endfunction

    function automatic result_t make_err(input err_t e);
        result_t r;
        r.found      = 1'b0;
        r.value_addr = '0;
        r.err        = e;
        return r;
    endfunction

endpackage

// File: rtl/fix_timeout_cnt.sv
// rtl/fix_timeout_cnt.sv - clearable wait counter flagging the last allowed cycle
module fix_timeout_cnt #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/fix_read_msg_ctrl.sv
// rtl/fix_read_msg_ctrl.sv - sequenced FIX message read: location lookup, bounded tag search, result
module fix_read_msg_ctrl
    import fix_read_pkg::*;
#(
    parameter int TAG_WIDTH      = 32,
    parameter int NUM_MESSAGE    = 10,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int IDX_WIDTH      = $clog2(NUM_MESSAGE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_req_i,
    input  logic [IDX_WIDTH-1:0]  read_idx_i,
    input  logic [TAG_WIDTH-1:0]  read_tag_i,
    output logic                  read_ack_o,
    output logic                  busy_o,
    output logic                  loc_rd_en_o,
    output logic [IDX_WIDTH-1:0]  loc_rd_idx_o,
    input  logic                  loc_rd_valid_i,
    input  logic                  loc_entry_valid_i,
    input  logic [ADDR_WIDTH-1:0] loc_start_addr_i,
    input  logic [ADDR_WIDTH-1:0] loc_end_addr_i,
    output logic                  search_valid_o,
    input  logic                  search_ready_i,
    output logic [TAG_WIDTH-1:0]  search_tag_o,
    output logic [ADDR_WIDTH-1:0] search_start_addr_o,
    output logic [ADDR_WIDTH-1:0] search_end_addr_o,
    input  logic                  search_done_i,
    input  logic                  search_found_i,
    input  logic [ADDR_WIDTH-1:0] search_value_addr_i,
    output logic                  done_o,
    output logic                  found_o,
    output logic [ADDR_WIDTH-1:0] value_addr_o,
    output logic [2:0]            err_o
);
    localparam logic [IDX_WIDTH:0] NUM_MSG = (IDX_WIDTH + 1)'(NUM_MESSAGE);

    state_t                state_q, state_d;
    result_t               res_q, res_d;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [ADDR_WIDTH-1:0] start_q, end_q;
    logic                  ack_q, busy_q, loc_en_q, search_valid_q, done_q;
    logic                  capture_req, capture_loc;
    logic                  tmo_clear, tmo_enable, tmo_expired;

    // Completing events are tested before tmo_expired so they win a same-cycle tie.
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        capture_req = 1'b0;
        capture_loc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (read_req_i) begin
                    capture_req = 1'b1;
                    if ({1'b0, read_idx_i} >= NUM_MSG) begin
                        state_d = ST_DONE;
                        res_d   = make_err(ERR_IDX);
                    end else begin
                        state_d = ST_LOC_RD;
                    end
                end
            end
            ST_LOC_RD: state_d = ST_LOC_WAIT;
            ST_LOC_WAIT: begin
                if (loc_rd_valid_i) begin
                    if (!loc_entry_valid_i) begin
                        state_d = ST_DONE;
                        res_d   = make_err(ERR_EMPTY);
                    end else if (loc_start_addr_i > loc_end_addr_i) begin
                        state_d = ST_DONE;
                        res_d   = make_err(ERR_RANGE);
                    end else begin
                        state_d     = ST_SEARCH_REQ;
                        capture_loc = 1'b1;
                    end
                end else if (tmo_expired) begin
                    state_d = ST_DONE;
                    res_d   = make_err(ERR_TIMEOUT);
                end
            end
            ST_SEARCH_REQ: begin
                if (search_ready_i) begin
                    state_d = ST_SEARCH_WAIT;
                end else if (tmo_expired) begin
                    state_d = ST_DONE;
                    res_d   = make_err(ERR_TIMEOUT);
                end
            end
            ST_SEARCH_WAIT: begin
                if (search_done_i) begin
                    state_d          = ST_DONE;
                    res_d.found      = search_found_i;
                    res_d.value_addr = RES_ADDR_WIDTH'(search_value_addr_i);
                    res_d.err        = ERR_NONE;
                end else if (tmo_expired) begin
                    state_d = ST_DONE;
                    res_d   = make_err(ERR_TIMEOUT);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign tmo_enable = is_timed(state_q);
    assign tmo_clear  = is_timed(state_d) && (state_d != state_q);

    fix_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            res_q          <= '0;
            idx_q          <= '0;
            tag_q          <= '0;
            start_q        <= '0;
            end_q          <= '0;
            ack_q          <= 1'b0;
            busy_q         <= 1'b0;
            loc_en_q       <= 1'b0;
            search_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            res_q          <= res_d;
            ack_q          <= capture_req;
            busy_q         <= (state_d != ST_IDLE);
            loc_en_q       <= (state_q == ST_LOC_RD);
            search_valid_q <= (state_d == ST_SEARCH_REQ);
            done_q         <= (state_d == ST_DONE);
            if (capture_req) begin
                idx_q <= read_idx_i;
                tag_q <= read_tag_i;
            end
            if (capture_loc) begin
                start_q <= loc_start_addr_i;
                end_q   <= loc_end_addr_i;
            end
        end
    end

    assign read_ack_o          = ack_q;
    assign busy_o              = busy_q;
    assign loc_rd_en_o         = loc_en_q;
    assign loc_rd_idx_o        = idx_q;
    assign search_valid_o      = search_valid_q;
    assign search_tag_o        = tag_q;
    assign search_start_addr_o = start_q;
    assign search_end_addr_o   = end_q;
    assign done_o              = done_q;
    assign found_o             = res_q.found;
    assign value_addr_o        = ADDR_WIDTH'(res_q.value_addr);
    assign err_o               = res_q.err;

endmodule

// File: tb/tb_fix_read_msg_ctrl.sv
// tb/tb_fix_read_msg_ctrl.sv - scoreboard bench for fix_read_msg_ctrl
module tb_fix_read_msg_ctrl;
    localparam int TW = 32;
    localparam int NM = 10;
    localparam int AW = 16;
    localparam int TO = 16;
    localparam int IW = 4;

    typedef struct {
        logic [2:0]    err;
        logic          found;
        logic [AW-1:0] value;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          read_req = 1'b0;
    logic [IW-1:0] read_idx = '0;
    logic [TW-1:0] read_tag = '0;
    logic          read_ack_o, busy_o, loc_rd_en_o, search_valid_o, done_o, found_o;
    logic [IW-1:0] loc_rd_idx_o;
    logic [TW-1:0] search_tag_o;
    logic [AW-1:0] search_start_addr_o, search_end_addr_o, value_addr_o;
    logic [2:0]    err_o;
    logic          loc_rd_valid = 1'b0, loc_entry_valid = 1'b0;
    logic [AW-1:0] loc_start = '0, loc_end = '0;
    logic          search_ready = 1'b0, search_done = 1'b0, search_found = 1'b0;
    logic [AW-1:0] search_value = '0;

    logic          cfg_entry_valid = 1'b1, cfg_never_done = 1'b0, cfg_found = 1'b0;
    logic [AW-1:0] cfg_start = '0, cfg_end = '0, cfg_value = '0;
    int            cfg_ready_delay = 0, cfg_done_delay = 1;
    logic [TW-1:0] exp_tag = '0;
    logic [AW-1:0] exp_start = '0, exp_end = '0;

    int checks = 0, errors = 0, cyc = 0;
    int ack_cnt = 0, loc_cnt = 0, sv_cycles = 0, xfer_cnt = 0, done_cnt = 0;
    int last_ack = 0, last_loc = 0, first_sv = 0, last_xfer = 0, last_sdone = 0, last_done = 0;
    logic sv_prev = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fix_read_msg_ctrl #(
        .TAG_WIDTH(TW), .NUM_MESSAGE(NM), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .read_req_i(read_req), .read_idx_i(read_idx), .read_tag_i(read_tag),
        .read_ack_o(read_ack_o), .busy_o(busy_o),
        .loc_rd_en_o(loc_rd_en_o), .loc_rd_idx_o(loc_rd_idx_o),
        .loc_rd_valid_i(loc_rd_valid), .loc_entry_valid_i(loc_entry_valid),
        .loc_start_addr_i(loc_start), .loc_end_addr_i(loc_end),
        .search_valid_o(search_valid_o), .search_ready_i(search_ready),
        .search_tag_o(search_tag_o), .search_start_addr_o(search_start_addr_o),
        .search_end_addr_o(search_end_addr_o),
        .search_done_i(search_done), .search_found_i(search_found),
        .search_value_addr_i(search_value),
        .done_o(done_o), .found_o(found_o), .value_addr_o(value_addr_o), .err_o(err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] err, input logic found, input logic [AW-1:0] value);
        exp_t e;
        e.err = err; e.found = found; e.value = value;
        return e;
    endfunction

    // Location table: answers the cycle after it sees the read strobe.
    initial begin : loc_model
        logic pend;
        pend = 1'b0;
        forever begin
            @(posedge clk); #1;
            loc_rd_valid = 1'b0;
            if (pend) begin
                loc_rd_valid    = 1'b1;
                loc_entry_valid = cfg_entry_valid;
                loc_start       = cfg_start;
                loc_end         = cfg_end;
                pend            = 1'b0;
            end
            if (loc_rd_en_o) pend = 1'b1;
        end
    end

    // Search engine: ready after cfg_ready_delay valid cycles, done cfg_done_delay cycles after transfer.
    initial begin : search_model
        int rdy_wait, done_wait;
        rdy_wait = 0; done_wait = 0;
        forever begin
            @(posedge clk); #1;
            search_done  = 1'b0;
            search_found = cfg_found;
            search_value = cfg_value;
            if (done_wait > 0) begin
                done_wait--;
                if (done_wait == 0) search_done = 1'b1;
            end
            if (search_valid_o) begin
                search_ready = (rdy_wait >= cfg_ready_delay);
                rdy_wait++;
            end else begin
                search_ready = 1'b0;
                rdy_wait     = 0;
            end
            if (search_valid_o && search_ready) begin
                rdy_wait = 0;
                if (!cfg_never_done) done_wait = cfg_done_delay;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (read_ack_o) begin ack_cnt++; last_ack = cyc; end
        if (loc_rd_en_o) begin loc_cnt++; last_loc = cyc; end
        if (search_valid_o) begin
            if (!sv_prev) first_sv = cyc;
            sv_cycles++;
            check("cmd_tag", 64'(search_tag_o), 64'(exp_tag));
            check("cmd_start", 64'(search_start_addr_o), 64'(exp_start));
            check("cmd_end", 64'(search_end_addr_o), 64'(exp_end));
            if (search_ready) begin xfer_cnt++; last_xfer = cyc; end
        end
        sv_prev = search_valid_o;
        if (search_done) last_sdone = cyc;
        if (done_o) begin
            done_cnt++;
            last_done = cyc;
            if (sb.size() == 0) begin
                check("done_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("res_err", 64'(err_o), 64'(e.err));
                check("res_found", 64'(found_o), 64'(e.found));
                check("res_value", 64'(value_addr_o), 64'(e.value));
            end
        end
    end

    task automatic send(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input exp_t e);
        int n;
        sb.push_back(e);
        @(posedge clk); #1;
        read_req = 1'b1; read_idx = idx; read_tag = tag;
        n = 0;
        do begin @(negedge clk); n++; end while (!read_ack_o && n < 200);
        check("ack_seen", 64'(read_ack_o), 64'd1);
        @(posedge clk); #1;
        read_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < 400) begin @(negedge clk); #1; n++; end
        check(tag, 64'(done_cnt >= target), 64'd1);
        repeat (3) @(posedge clk);
    endtask

    task automatic set_cmd(input logic [TW-1:0] tag, input logic [AW-1:0] s, input logic [AW-1:0] e);
        exp_tag = tag; exp_start = s; exp_end = e;
        cfg_entry_valid = 1'b1; cfg_start = s; cfg_end = e;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        int d0, l0, s0, x0, a0, done1, n;
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", 64'(|{read_ack_o, busy_o, loc_rd_en_o, loc_rd_idx_o, search_valid_o,
              search_tag_o, search_start_addr_o, search_end_addr_o, done_o, found_o,
              value_addr_o, err_o}), 64'd0);
        rst_n = 1'b1;

        // Normal read with nominal latency
        set_cmd(32'd35, 16'h0010, 16'h0040);
        cfg_ready_delay = 0; cfg_done_delay = 2; cfg_found = 1'b1; cfg_value = 16'h0023;
        d0 = done_cnt; l0 = loc_cnt; s0 = sv_cycles; x0 = xfer_cnt;
        send(4'd3, 32'd35, mk(3'd0, 1'b1, 16'h0023));
        wait_done(d0 + 1, "t1_done_seen");
        check("t1_loc_lat", 64'(last_loc - last_ack), 64'd1);
        check("t1_sv_lat", 64'(first_sv - last_ack), 64'd3);
        check("t1_done_lat", 64'(last_done - last_sdone), 64'd1);
        check("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check("t1_loc_once", 64'(loc_cnt - l0), 64'd1);
        check("t1_xfer_once", 64'(xfer_cnt - x0), 64'd1);
        check("t1_sv_cycles", 64'(sv_cycles - s0), 64'd1);
        check("t1_idle", 64'(busy_o), 64'd0);

        // Out-of-range index: no table read, no search
        d0 = done_cnt; l0 = loc_cnt; s0 = sv_cycles;
        send(4'd10, 32'd7, mk(3'd1, 1'b0, 16'h0));
        wait_done(d0 + 1, "t2_done_seen");
        check("t2_no_loc", 64'(loc_cnt - l0), 64'd0);
        check("t2_no_sv", 64'(sv_cycles - s0), 64'd0);

        // Empty slot, then reversed range
        cfg_entry_valid = 1'b0;
        d0 = done_cnt; s0 = sv_cycles;
        send(4'd5, 32'd8, mk(3'd2, 1'b0, 16'h0));
        wait_done(d0 + 1, "t3_done_seen");
        check("t3_no_sv", 64'(sv_cycles - s0), 64'd0);
        set_cmd(32'd9, 16'h0050, 16'h0020);
        d0 = done_cnt; s0 = sv_cycles;
        send(4'd6, 32'd9, mk(3'd3, 1'b0, 16'h0));
        wait_done(d0 + 1, "t4_done_seen");
        check("t4_no_sv", 64'(sv_cycles - s0), 64'd0);

        // Backpressure: ready low for 7 cycles
        set_cmd(32'd44, 16'h0100, 16'h01ff);
        cfg_ready_delay = 7; cfg_done_delay = 3; cfg_found = 1'b1; cfg_value = 16'h0150;
        d0 = done_cnt; s0 = sv_cycles; x0 = xfer_cnt;
        send(4'd9, 32'd44, mk(3'd0, 1'b1, 16'h0150));
        wait_done(d0 + 1, "t5_done_seen");
        check("t5_sv_cycles", 64'(sv_cycles - s0), 64'd8);
        check("t5_xfer_once", 64'(xfer_cnt - x0), 64'd1);
        check("t5_done_lat", 64'(last_done - last_sdone), 64'd1);

        // Zero-length range is legal; tag not found
        set_cmd(32'd12, 16'h0080, 16'h0080);
        cfg_ready_delay = 0; cfg_done_delay = 1; cfg_found = 1'b0; cfg_value = 16'h0000;
        d0 = done_cnt; x0 = xfer_cnt;
        send(4'd0, 32'd12, mk(3'd0, 1'b0, 16'h0));
        wait_done(d0 + 1, "t5b_done_seen");
        check("t5b_xfer_once", 64'(xfer_cnt - x0), 64'd1);

        // Search timeout, plus a second request held while busy
        set_cmd(32'd77, 16'h0010, 16'h0020);
        cfg_never_done = 1'b1;
        d0 = done_cnt;
        send(4'd2, 32'd77, mk(3'd4, 1'b0, 16'h0));
        repeat (5) @(posedge clk); #1;
        check("t6_busy", 64'(busy_o), 64'd1);
        a0 = ack_cnt;
        sb.push_back(mk(3'd1, 1'b0, 16'h0));
        read_req = 1'b1; read_idx = 4'd10; read_tag = 32'd1;
        n = 0;
        while (done_cnt < d0 + 1 && n < 400) begin @(negedge clk); #1; n++; end
        check("t6_tmo_done_seen", 64'(done_cnt >= d0 + 1), 64'd1);
        done1 = last_done;
        check("t6_tmo_lat", 64'(done1 - last_xfer), 64'd17);
        check("t6_no_early_ack", 64'(ack_cnt - a0), 64'd0);
        n = 0;
        while (ack_cnt == a0 && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        read_req = 1'b0;
        check("t6_ack2_cyc", 64'(last_ack - done1), 64'd2);
        wait_done(d0 + 2, "t6_done2_seen");
        check("t6_ack2_once", 64'(ack_cnt - a0), 64'd1);

        // Reset in SEARCH_WAIT: outputs clear at once, no result
        set_cmd(32'd55, 16'h0030, 16'h0060);
        x0 = xfer_cnt;
        send(4'd1, 32'd55, mk(3'd0, 1'b1, 16'h0));
        n = 0;
        while (xfer_cnt == x0 && n < 100) begin @(negedge clk); #1; n++; end
        repeat (3) @(posedge clk); #1;
        check("t7_busy", 64'(busy_o), 64'd1);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_outputs", 64'(|{read_ack_o, busy_o, loc_rd_en_o, loc_rd_idx_o, search_valid_o,
              search_tag_o, search_start_addr_o, search_end_addr_o, done_o, found_o,
              value_addr_o, err_o}), 64'd0);
        repeat (3) @(posedge clk); #1;
        check("t7_no_done", 64'(done_cnt - d0), 64'd0);
        sb.delete();
        cfg_never_done = 1'b0;
        rst_n = 1'b1;

        set_cmd(32'd21, 16'h0200, 16'h02ff);
        cfg_found = 1'b1; cfg_value = 16'h0242;
        d0 = done_cnt;
        send(4'd7, 32'd21, mk(3'd0, 1'b1, 16'h0242));
        wait_done(d0 + 1, "t8_done_seen");
        check("t8_done_lat", 64'(last_done - last_sdone), 64'd1);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
